seq_multiplier: RTL

Parametrised iterative shift-add multiplier. It is the sequential successor to the team's combinational 16x16 `main` multiplier.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Computes one multiplier bit per clock and presents the full-width product until the consumer takes it.
- Supports signed and unsigned modes per transaction.
- Sits between operand producers and result consumers in the arithmetic datapath, where area matters more than throughput.

---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/seq_multiplier.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package seq_mul_pkg;

    localparam int SEQ_MUL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to hold an iteration count in 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed or
// unsigned per transaction, full 2*WIDTH product held until consumed.
// Optional build macro SEQ_MULTIPLIER_EARLY_TERM_EN: finish as soon as the
// remaining multiplier bits are all zero (same results, shorter latency).
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     first_num,
    input  logic [WIDTH-1:0]     second_num,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   solution
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    state_e               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   solution_q, solution_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiplicand pre-shifted one place per iteration, so the add is always
    // aligned with the current multiplier bit without a barrel shifter.
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;

    // Operand magnitudes; -2^(WIDTH-1) negates to its own bit pattern, which
    // read as unsigned is exactly the required magnitude.
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   acc_step, acc_step_fix, acc_now_fix;

    assign a_neg = is_signed & first_num[WIDTH-1];
    assign b_neg = is_signed & second_num[WIDTH-1];
    assign mag_a = a_neg ? -first_num  : first_num;
    assign mag_b = b_neg ? -second_num : second_num;

    assign acc_step     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign acc_step_fix = neg_q ? -acc_step : acc_step;
    assign acc_now_fix  = neg_q ? -acc_q    : acc_q;

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        solution_d  = solution_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d    = {{WIDTH{1'b0}}, mag_a};
                    mplier_d   = mag_b;
                    neg_d      = a_neg ^ b_neg;
                    acc_d      = '0;
                    cnt_d      = CNT_LOAD;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
                if (mplier_q == '0) begin
                    solution_d  = acc_now_fix;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else
`endif
                begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        solution_d  = acc_step_fix;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            solution_q  <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            solution_q  <= solution_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign solution  = solution_q;

endmodule
